// File: rtl/rv_alu_arbiter_if.sv
// Request/response bus between two ALU clients and the shared ALU arbiter.
// Requester k occupies slice k of every req_* vector.
interface rv_alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*17-1:0]     req_insn;
    logic [2*XLEN-1:0]   req_a;
    logic [2*XLEN-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [XLEN-1:0]     rsp_result;
    logic                rsp_illegal;

    // client side: drives requests, consumes responses
    modport master (
        output req_valid, req_insn, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_illegal
    );

    // arbiter side
    modport slave (
        input  req_valid, req_insn, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_illegal
    );
endinterface

// File: rtl/rv_alu_arbiter.sv
// Two-client round-robin arbiter in front of one ADD/SUB/AND/OR ALU.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (deliver).
module rv_alu_arbiter #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv_alu_arbiter_if.slave      bus,
    output logic                 busy,
    output logic [ILL_CNT_W-1:0] ill_cnt
);
    localparam logic [16:0] INSN_ADD = 17'b0000000_000_0110011;
    localparam logic [16:0] INSN_SUB = 17'b0100000_000_0110011;
    localparam logic [16:0] INSN_AND = 17'b0000000_111_0110011;
    localparam logic [16:0] INSN_OR  = 17'b0000000_110_0110011;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [16:0]     insn;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            id;
    } op_t;

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] result;
        logic            illegal;
    } rsp_t;

    state_t          state, state_nxt;
    logic            rr_ptr;
    logic            gnt;
    logic            gnt_vld;
    logic            req_hs;
    logic            rsp_hs;
    op_t             op_q;
    rsp_t            rsp_q;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;

    // rr_ptr wins if it is asking, otherwise the other requester
    assign gnt     = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign gnt_vld = |bus.req_valid;
    assign req_hs  = (state == IDLE) && gnt_vld;
    assign rsp_hs  = (state == RESP) && bus.rsp_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs; ready follows valid, only while IDLE
    always_comb begin
        bus.req_ready = 2'b00;
        if (state == IDLE && gnt_vld) bus.req_ready[gnt] = 1'b1;
        bus.rsp_valid = (state == RESP);
        busy          = (state != IDLE);
    end

    // capture the granted request; ignored in every other cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
        end else if (req_hs) begin
            op_q.insn <= gnt ? bus.req_insn[33:17]      : bus.req_insn[16:0];
            op_q.a    <= gnt ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
            op_q.b    <= gnt ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
            op_q.id   <= gnt;
        end
    end

    // R-type decode of the four supported ops; anything else is illegal with result 0
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_q.insn)
            INSN_ADD: alu_res = op_q.a + op_q.b;
            INSN_SUB: alu_res = op_q.a - op_q.b;
            INSN_AND: alu_res = op_q.a & op_q.b;
            INSN_OR:  alu_res = op_q.a | op_q.b;
            default:  alu_ill = 1'b1;
        endcase
    end

    // response payload loads in EXEC and holds until the next EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             rsp_q <= '0;
        else if (state == EXEC) rsp_q <= '{id: op_q.id, result: alu_res, illegal: alu_ill};
    end

    // on delivery hand priority to the other requester and count illegal ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b0;
            ill_cnt <= '0;
        end else if (rsp_hs) begin
            rr_ptr <= ~rsp_q.id;
            if (rsp_q.illegal && ill_cnt != '1) ill_cnt <= ill_cnt + ILL_CNT_W'(1);
        end
    end

    assign bus.rsp_id      = rsp_q.id;
    assign bus.rsp_result  = rsp_q.result;
    assign bus.rsp_illegal = rsp_q.illegal;
endmodule
